fifo_rd_packer: RTL and testbench

Read-side consumer for the asynchronous FIFO, living entirely in the FIFO's read clock domain. It pops narrow words from the FIFO read port and packs PACK_RATIO consecutive words into one wide word. The wide word is presented downstream on a valid/ready stream. Packing is little-endian: the first popped word lands in lane 0 (LSBs).

---
 rtl/fifo_rd_packer_if.sv | 51 +++++
 rtl/fifo_rd_packer.sv | 138 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_packer_if.sv
`default_nettype none
// ============================================================================
// Interface     : fifo_rd_packer_if
// Description   : Bundles the FIFO read port and the packed output stream of
//                 fifo_rd_packer.
//                 master : packer side (pops FIFO, drives the output stream)
//                 slave  : environment side (FIFO read port, downstream sink)
//                 Signals:
//                   fifoEmpty  FIFO empty flag
//                   fifoREn    FIFO pop strobe
//                   fifoRData  FIFO read data, valid the cycle after a pop
//                   outData    packed word, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//                   outValid   outData holds a word
//                   outReady   downstream accepts the word
//                   flush      (PACKER_FLUSH_EN only) emit a partial word
//                   outKeep    (PACKER_FLUSH_EN only) per-lane valid mask
// Config macro  : PACKER_FLUSH_EN adds flush/outKeep
// Revision      : 1.0 - initial release
// ============================================================================
interface fifo_rd_packer_if #(
  parameter int DATA_WIDTH = 4,
  parameter int PACK_RATIO = 4
);
  logic                           fifoEmpty;
  logic                           fifoREn;
  logic [DATA_WIDTH-1:0]          fifoRData;
  logic [DATA_WIDTH*PACK_RATIO-1:0] outData;
  logic                           outValid;
  logic                           outReady;
`ifdef PACKER_FLUSH_EN
  logic                           flush;
  logic [PACK_RATIO-1:0]          outKeep;
`endif

  modport master (
    input  fifoEmpty, fifoRData, outReady,
    output fifoREn, outData, outValid
`ifdef PACKER_FLUSH_EN
    , input flush, output outKeep
`endif
  );

  modport slave (
    output fifoEmpty, fifoRData, outReady,
    input  fifoREn, outData, outValid
`ifdef PACKER_FLUSH_EN
    , output flush, input outKeep
`endif
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module        : fifo_rd_packer
// Description   : Read-side consumer of the asynchronous FIFO. Pops narrow
//                 words and packs PACK_RATIO of them little-endian (first
//                 word in lane 0) into one wide word on a valid/ready stream.
// Ports         : rClk   read-domain clock
//                 rRstN  asynchronous active-low reset
//                 bus    fifo_rd_packer_if.master (FIFO read port + stream)
// Config macro  : PACKER_FLUSH_EN - adds flush input and outKeep lane mask;
//                 a flush emits the partially filled accumulator.
// Revision      : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 4,
  parameter int PACK_RATIO = 4
) (
  input  logic                rClk,
  input  logic                rRstN,
  fifo_rd_packer_if.master    bus
);
  localparam int OUT_W = DATA_WIDTH * PACK_RATIO;
  localparam int CW    = $clog2(PACK_RATIO + 1);
  localparam logic [CW:0] FULL = (CW + 1)'(PACK_RATIO);

  logic [OUT_W-1:0] acc;
  logic [CW-1:0]    lane_cnt;
  logic             inflight;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             flush_pend;

  logic             full;
  logic             xfer;
  logic [CW:0]      eff;
  logic             pop;
  logic [CW-1:0]    wr_lane;
  logic             partial;
  logic [OUT_W-1:0] partial_data;

  always_comb begin
    full    = ({1'b0, lane_cnt} == FULL);
    xfer    = full && (!out_valid || bus.outReady);
    // Occupancy the accumulator will have after this edge, counting the word
    // already in flight; a pop is only issued if its data has a lane to land in.
    eff     = {1'b0, (xfer ? {CW{1'b0}} : lane_cnt)} + (CW + 1)'(inflight);
    pop     = rRstN && !bus.fifoEmpty && (eff < FULL) && !flush_pend;
    wr_lane = xfer ? {CW{1'b0}} : lane_cnt;
  end

`ifdef PACKER_FLUSH_EN
  logic [PACK_RATIO-1:0] keep_mask;
  logic                  flush_clear;
  logic                  out_keep;

  always_comb begin
    keep_mask    = '0;
    partial_data = '0;
    for (int k = 0; k < PACK_RATIO; k++) begin
      if ((CW + 1)'(k) < {1'b0, lane_cnt}) begin
        keep_mask[k] = 1'b1;
        partial_data[k*DATA_WIDTH +: DATA_WIDTH] = acc[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    // A flush only acts once the last popped word has landed.
    partial     = flush_pend && !inflight && (lane_cnt != '0) && !full &&
                  (!out_valid || bus.outReady);
    flush_clear = flush_pend && !inflight && ((lane_cnt == '0) || partial);
  end

  logic [PACK_RATIO-1:0] keep_r;

  always_ff @(posedge rClk or negedge rRstN) begin
    if (!rRstN) begin
      flush_pend <= 1'b0;
      keep_r     <= '0;
    end else begin
      if (!flush_pend && bus.flush)
        flush_pend <= 1'b1;
      else if (flush_clear)
        flush_pend <= 1'b0;
      if (xfer)
        keep_r <= '1;
      else if (partial)
        keep_r <= keep_mask;
    end
  end

  assign out_keep    = 1'b0;
  assign bus.outKeep = keep_r;
`else
  assign flush_pend   = 1'b0;
  assign partial      = 1'b0;
  assign partial_data = '0;
`endif

  always_ff @(posedge rClk or negedge rRstN) begin
    if (!rRstN) begin
      acc       <= '0;
      lane_cnt  <= '0;
      inflight  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      inflight <= pop;

      if (inflight) begin
        for (int k = 0; k < PACK_RATIO; k++) begin
          if (wr_lane == CW'(k))
            acc[k*DATA_WIDTH +: DATA_WIDTH] <= bus.fifoRData;
        end
      end

      // On xfer a word landing this cycle starts the next output word.
      if (xfer)
        lane_cnt <= CW'(inflight);
      else if (partial)
        lane_cnt <= '0;
      else if (inflight)
        lane_cnt <= lane_cnt + CW'(1);

      if (xfer) begin
        out_data  <= acc;
        out_valid <= 1'b1;
      end else if (partial) begin
        out_data  <= partial_data;
        out_valid <= 1'b1;
      end else if (out_valid && bus.outReady) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.fifoREn  = pop;
  assign bus.outData  = out_data;
  assign bus.outValid = out_valid;
endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module        : tb_fifo_rd_packer
// Description   : Directed self-checking bench for fifo_rd_packer with a
//                 behavioural FIFO read port and an output-word collector.
// Config macro  : PACKER_FLUSH_EN enables the flush scenario
// Revision      : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;
  logic clk = 1'b0;
  logic rRstN = 1'b0;
  logic outReady = 1'b1;
  logic flush = 1'b0;
  logic fifo_clr = 1'b1;

  logic [3:0] mem [0:31];
  logic [5:0] wp = '0;
  logic [5:0] rp;
  logic [3:0] rdata;
  logic       popped_empty;

  logic [15:0] got [$];
  logic [3:0]  got_keep [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_rd_packer_if #(.DATA_WIDTH(4), .PACK_RATIO(4)) bus ();

  fifo_rd_packer #(.DATA_WIDTH(4), .PACK_RATIO(4)) dut (
    .rClk  (clk),
    .rRstN (rRstN),
    .bus   (bus)
  );

  assign bus.fifoEmpty = (rp == wp);
  assign bus.fifoRData = rdata;
  assign bus.outReady  = outReady;
`ifdef PACKER_FLUSH_EN
  assign bus.flush     = flush;
`endif

  // FIFO read port: data appears the cycle after the pop is sampled.
  always @(posedge clk) begin
    if (fifo_clr) begin
      rp           <= '0;
      rdata        <= '0;
      popped_empty <= 1'b0;
    end else if (bus.fifoREn) begin
      if (rp == wp) popped_empty <= 1'b1;
      rdata <= mem[rp[4:0]];
      rp    <= rp + 6'd1;
    end
  end

  always @(negedge clk) begin
    if (rRstN && bus.outValid && bus.outReady) begin
      got.push_back(bus.outData);
`ifdef PACKER_FLUSH_EN
      got_keep.push_back(bus.outKeep);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] v);
    mem[wp[4:0]] = v;
    wp = wp + 6'd1;
  endtask

  task automatic apply_reset();
    rRstN    = 1'b0;
    fifo_clr = 1'b1;
    outReady = 1'b1;
    flush    = 1'b0;
    wp       = '0;
    got.delete();
    got_keep.delete();
    step(2);
    fifo_clr = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    apply_reset();
    for (int v = 1; v <= 4; v++) push(4'(v));
    for (int c = 0; c < 4; c++) begin
      step(1);
      checks++;
      if (bus.fifoREn !== 1'b0) begin
        errors++; $display("FAIL reset_fifoREn got %b want 0", bus.fifoREn);
      end
      checks++;
      if (bus.outValid !== 1'b0) begin
        errors++; $display("FAIL reset_outValid got %b want 0", bus.outValid);
      end
      checks++;
      if (bus.outData !== 16'h0000) begin
        errors++; $display("FAIL reset_outData got %h want 0000", bus.outData);
      end
    end
    rRstN = 1'b1;
    #1;
    checks++;
    if (bus.fifoREn !== 1'b1) begin
      errors++; $display("FAIL reset_release_pop got %b want 1", bus.fifoREn);
    end
  endtask

  task automatic test_basic();
    int first_ren;
    int first_val;
    first_ren = -1;
    first_val = -1;
    apply_reset();
    for (int v = 1; v <= 8; v++) push(4'(v));
    rRstN = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (first_ren < 0 && bus.fifoREn === 1'b1) first_ren = i;
      if (first_val < 0 && bus.outValid === 1'b1) first_val = i;
      step(1);
    end
    checks++;
    if (first_ren < 0 || first_val < 0 || (first_val - first_ren) != 6) begin
      errors++; $display("FAIL basic_latency got %0d want 6", first_val - first_ren);
    end
    checks++;
    if (rp !== 6'd8) begin
      errors++; $display("FAIL basic_pops got %0d want 8", rp);
    end
    checks++;
    if (popped_empty !== 1'b0) begin
      errors++; $display("FAIL basic_pop_empty got %b want 0", popped_empty);
    end
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL basic_count got %0d want 2", got.size());
    end else begin
      checks++;
      if (got[0] !== 16'h4321) begin
        errors++; $display("FAIL basic_word0 got %h want 4321", got[0]);
      end
      checks++;
      if (got[1] !== 16'h8765) begin
        errors++; $display("FAIL basic_word1 got %h want 8765", got[1]);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    for (int v = 1; v <= 12; v++) push(4'(v));
    outReady = 1'b0;
    rRstN    = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (bus.outValid === 1'b1) begin
        checks++;
        if (bus.outData !== 16'h4321) begin
          errors++; $display("FAIL stall_hold got %h want 4321", bus.outData);
        end
      end
    end
    checks++;
    if (bus.outValid !== 1'b1) begin
      errors++; $display("FAIL stall_valid got %b want 1", bus.outValid);
    end
    checks++;
    if (rp !== 6'd8) begin
      errors++; $display("FAIL stall_pops got %0d want 8", rp);
    end
    outReady = 1'b1;
    step(30);
    checks++;
    if (rp !== 6'd12) begin
      errors++; $display("FAIL stall_total_pops got %0d want 12", rp);
    end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL stall_count got %0d want 3", got.size());
    end else begin
      checks++;
      if (got[0] !== 16'h4321 || got[1] !== 16'h8765 || got[2] !== 16'hCBA9) begin
        errors++;
        $display("FAIL stall_order got %h %h %h want 4321 8765 cba9", got[0], got[1], got[2]);
      end
    end
  endtask

  task automatic test_empty();
    apply_reset();
    push(4'h9); push(4'hA); push(4'hB); push(4'hC); push(4'hD); push(4'hE);
    rRstN = 1'b1;
    step(14);
    for (int c = 0; c < 6; c++) begin
      step(1);
      checks++;
      if (bus.fifoREn !== 1'b0) begin
        errors++; $display("FAIL empty_no_pop got %b want 0", bus.fifoREn);
      end
    end
    checks++;
    if (dut.lane_cnt !== 3'd2) begin
      errors++; $display("FAIL empty_lanecnt got %0d want 2", dut.lane_cnt);
    end
    checks++;
    if (rp !== 6'd6 || popped_empty !== 1'b0) begin
      errors++; $display("FAIL empty_pops got %0d/%b want 6/0", rp, popped_empty);
    end
    push(4'h1); push(4'h2);
    step(20);
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL empty_count got %0d want 2", got.size());
    end else begin
      checks++;
      if (got[0] !== 16'hCBA9) begin
        errors++; $display("FAIL empty_word0 got %h want cba9", got[0]);
      end
      checks++;
      if (got[1] !== 16'h21ED) begin
        errors++; $display("FAIL empty_word1 got %h want 21ed", got[1]);
      end
    end
  endtask

`ifdef PACKER_FLUSH_EN
  task automatic test_flush();
    apply_reset();
    push(4'h5); push(4'h6); push(4'h7);
    rRstN = 1'b1;
    step(10);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    push(4'h8);
    #1;
    checks++;
    if (bus.fifoREn !== 1'b0) begin
      errors++; $display("FAIL flush_pop_blocked got %b want 0", bus.fifoREn);
    end
    step(1);
    checks++;
    if (bus.outValid !== 1'b1 || bus.outData !== 16'h0765) begin
      errors++; $display("FAIL flush_word got %b/%h want 1/0765", bus.outValid, bus.outData);
    end
    checks++;
    if (bus.outKeep !== 4'b0111) begin
      errors++; $display("FAIL flush_keep got %b want 0111", bus.outKeep);
    end
    push(4'h9); push(4'hA); push(4'hB);
    step(15);
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL flush_count got %0d want 2", got.size());
    end else begin
      checks++;
      if (got[1] !== 16'hBA98 || got_keep[1] !== 4'hF) begin
        errors++; $display("FAIL flush_next got %h/%b want ba98/1111", got[1], got_keep[1]);
      end
    end
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(8);
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL flush_empty_word got %0d want 2", got.size());
    end
    checks++;
    if (dut.flush_pend !== 1'b0) begin
      errors++; $display("FAIL flush_pend_clear got %b want 0", dut.flush_pend);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_empty();
`ifdef PACKER_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
